fb_arbiter: RTL

Frame-buffer port arbiter sharing one single-port BRAM between the camera pixel writer and the VGA pixel reader. Camera writes arrive in bursts at the camera pixel rate and are absorbed by a small write FIFO. VGA reads have strict priority and fixed latency. Writes drain whenever the VGA side is idle, mainly during blanking. Sits between the camera capture/downsample logic and the VGA pixel pipeline in the camera-to-display path.

---
 rtl/fb_pkg.sv | 8 +
 rtl/fb_arbiter_if.sv | 31 +++
 rtl/fb_wr_fifo.sv | 38 +++
 rtl/fb_arbiter.sv | 68 ++++++
 4 files changed

// File: rtl/fb_pkg.sv
// fb_pkg: shared frame-buffer types and default geometry/width constants.
package fb_pkg;
  typedef enum logic [1:0] {GNT_NONE, GNT_RD, GNT_WR} grant_e;
  localparam int FB_WIDTH  = 320;
  localparam int FB_HEIGHT = 240;
  localparam int FB_ADDR_W = 17;
  localparam int FB_DATA_W = 12;
endpackage

// File: rtl/fb_arbiter_if.sv
// fb_arbiter_if: camera write, VGA read and BRAM port bundle of the frame-buffer arbiter.
interface fb_arbiter_if
  import fb_pkg::*;
#(
  parameter int ADDR_W = FB_ADDR_W,
  parameter int DATA_W = FB_DATA_W,
  parameter int LVL_W  = 4
);
  logic              cam_wr_valid;
  logic [ADDR_W-1:0] cam_wr_addr;
  logic [DATA_W-1:0] cam_wr_data;
  logic              cam_wr_ready;
  logic              vga_rd_req;
  logic [ADDR_W-1:0] vga_rd_addr;
  logic [DATA_W-1:0] vga_rd_data;
  logic              vga_rd_valid;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [LVL_W-1:0]  fifo_level;
  modport slave (
    input  cam_wr_valid, cam_wr_addr, cam_wr_data, vga_rd_req, vga_rd_addr, mem_rdata,
    output cam_wr_ready, vga_rd_data, vga_rd_valid, mem_en, mem_we, mem_addr, mem_wdata, fifo_level
  );
  modport master (
    output cam_wr_valid, cam_wr_addr, cam_wr_data, vga_rd_req, vga_rd_addr, mem_rdata,
    input  cam_wr_ready, vga_rd_data, vga_rd_valid, mem_en, mem_we, mem_addr, mem_wdata, fifo_level
  );
endinterface

// File: rtl/fb_wr_fifo.sv
// fb_wr_fifo: synchronous {addr,data} write FIFO; when empty the head shows the
// incoming beat so a push can be popped in the same cycle.
module fb_wr_fifo
  import fb_pkg::*;
#(
  parameter int W     = FB_ADDR_W + FB_DATA_W,
  parameter int DEPTH = 8,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     head,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  assign empty = level == '0;
  assign full  = level == LVL_W'(DEPTH);
  assign head  = empty ? din : mem[rd_ptr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(pop);
      level  <= level + LVL_W'(push) - LVL_W'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
endmodule

// File: rtl/fb_arbiter.sv
// fb_arbiter: single-port BRAM arbiter, VGA reads strictly over buffered camera writes.
// Define FB_ARBITER_STATS_EN to add drop_count/max_level statistics outputs.
module fb_arbiter
  import fb_pkg::*;
#(
  parameter int ADDR_W     = FB_ADDR_W,
  parameter int DATA_W     = FB_DATA_W,
  parameter int FIFO_DEPTH = 8,
  parameter int RD_LAT     = 2
) (
  input  logic        clk_100mhz,
  input  logic        rst_n,
  fb_arbiter_if.slave bus
`ifdef FB_ARBITER_STATS_EN
  ,
  output logic [15:0] drop_count,
  output logic [15:0] max_level
`endif
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  grant_e                     state, nxt;
  logic                       push, pop, full, empty;
  logic [ADDR_W+DATA_W-1:0]   head;
  logic [LVL_W-1:0]           level;
  logic [RD_LAT-1:0]          vld;
  logic [DATA_W-1:0]          rd_q;
  assign push = bus.cam_wr_valid && !full;
  assign nxt  = bus.vga_rd_req ? GNT_RD : (!empty || push) ? GNT_WR : GNT_NONE;
  assign pop  = nxt == GNT_WR;
  assign bus.cam_wr_ready = !full;
  assign bus.fifo_level   = level;
  assign bus.vga_rd_valid = vld[RD_LAT-1];
  assign bus.vga_rd_data  = vld[RD_LAT-1] ? bus.mem_rdata : rd_q;
  fb_wr_fifo #(.W(ADDR_W + DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk_100mhz), .rst_n(rst_n), .push(push), .pop(pop),
    .din({bus.cam_wr_addr, bus.cam_wr_data}), .head(head),
    .full(full), .empty(empty), .level(level)
  );
  always_ff @(posedge clk_100mhz or negedge rst_n)
    if (!rst_n) begin
      state         <= GNT_NONE;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      vld           <= '0;
      rd_q          <= '0;
    end else begin
      state      <= nxt;
      bus.mem_en <= nxt != GNT_NONE;
      bus.mem_we <= nxt == GNT_WR;
      if (nxt == GNT_RD) bus.mem_addr <= bus.vga_rd_addr;
      else if (nxt == GNT_WR) {bus.mem_addr, bus.mem_wdata} <= head;
      // valid trails the cycle the BRAM actually sees the read
      vld <= RD_LAT'({vld, state == GNT_RD});
      if (vld[RD_LAT-1]) rd_q <= bus.mem_rdata;
    end
`ifdef FB_ARBITER_STATS_EN
  always_ff @(posedge clk_100mhz or negedge rst_n)
    if (!rst_n) begin
      drop_count <= '0;
      max_level  <= '0;
    end else begin
      if (bus.cam_wr_valid && full && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      if (16'(level) > max_level) max_level <= 16'(level);
    end
`endif
endmodule
